// File: rtl/raygen_pkg.sv
// raygen_pkg: shared types and constants for the ray direction generator.
package raygen_pkg;
    localparam int FRAC_BITS = 16;

    typedef struct packed {
        logic signed [31:0] x;
        logic signed [31:0] y;
        logic signed [31:0] z;
    } vec3_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/ray_axis_mac.sv
// ray_axis_mac: one ray component through offset, multiply and add/reduce stages with stall enable.
// RAYGEN_SAT_EN: saturate the 34-bit sum to 32 bits; otherwise the low 32 bits are kept.
module ray_axis_mac #(
    parameter int XW = 10,
    parameter int YW = 9,
    parameter int SHIFT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic signed [XW-1:0] dx,
    input  logic signed [YW-1:0] dy,
    input  logic signed [31:0] fwd,
    input  logic signed [31:0] right,
    input  logic signed [31:0] up,
    output logic signed [31:0] ray
);
    localparam int PW = (XW > YW ? XW : YW) + 32;
`ifdef RAYGEN_SAT_EN
    localparam int SW = 34;
`else
    localparam int SW = 32;
`endif

    logic signed [XW-1:0] dx_q;
    logic signed [YW-1:0] dy_q;
    logic signed [PW-1:0] prod_r, prod_u;
    logic signed [31:0]   fwd_q;
    logic signed [SW-1:0] sum;
    logic signed [31:0]   red;

    assign sum = SW'(fwd_q) + SW'(prod_r >>> SHIFT) + SW'(prod_u >>> SHIFT);
`ifdef RAYGEN_SAT_EN
    assign red = (sum[33:31] == 3'b000 || sum[33:31] == 3'b111) ? sum[31:0] :
                 sum[33] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
`else
    assign red = sum;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            dx_q   <= '0;
            dy_q   <= '0;
            prod_r <= '0;
            prod_u <= '0;
            fwd_q  <= '0;
            ray    <= '0;
        end else if (en) begin
            dx_q   <= dx;
            dy_q   <= dy;
            prod_r <= PW'(dx_q) * PW'(right);
            prod_u <= PW'(dy_q) * PW'(up);
            fwd_q  <= fwd;
            ray    <= red;
        end
endmodule

// File: rtl/ray_direction_gen.sv
// ray_direction_gen: streams one unnormalised ray direction per pixel in raster order.
// RAYGEN_SAT_EN (see ray_axis_mac) selects saturating instead of wrapping output reduction.
module ray_direction_gen
    import raygen_pkg::*;
#(
    parameter int H_RES = 320,
    parameter int V_RES = 180,
    parameter int PIX_SHIFT = FRAC_BITS / 2,
    localparam int HW = $clog2(H_RES),
    localparam int VW = $clog2(V_RES)
) (
    input  logic          clk_100mhz,
    input  logic          rst_in,
    input  logic          start_in,
    input  logic [31:0]   x_forward_in,
    input  logic [31:0]   y_forward_in,
    input  logic [31:0]   z_forward_in,
    input  logic [31:0]   x_up_in,
    input  logic [31:0]   y_up_in,
    input  logic [31:0]   z_up_in,
    input  logic [31:0]   x_right_in,
    input  logic [31:0]   y_right_in,
    input  logic [31:0]   z_right_in,
    output logic          busy_out,
    output logic          ray_valid_out,
    input  logic          ray_ready_in,
    output logic [31:0]   ray_x_out,
    output logic [31:0]   ray_y_out,
    output logic [31:0]   ray_z_out,
    output logic [HW-1:0] pix_h_out,
    output logic [VW-1:0] pix_v_out,
    output logic          ray_last_out
);
    localparam logic [HW:0] H_MID = (HW+1)'(H_RES / 2);
    localparam logic [VW:0] V_MID = (VW+1)'(V_RES / 2);

    state_t state, next_state;
    vec3_t fwd, up, right;
    logic [HW-1:0] h_cnt, h1, h2;
    logic [VW-1:0] v_cnt, v1, v2;
    logic [2:0] vld, last;
    logic en, issue, h_end, v_end;
    logic signed [HW:0] dx;
    logic signed [VW:0] dy;

    // A held output beat freezes the whole pipeline, counters included.
    assign en = !(ray_valid_out && !ray_ready_in);
    assign issue = (state == RUN) && en;
    assign h_end = h_cnt == HW'(H_RES - 1);
    assign v_end = v_cnt == VW'(V_RES - 1);
    assign dx = {1'b0, h_cnt} - H_MID;
    assign dy = V_MID - {1'b0, v_cnt};
    assign busy_out = state != IDLE;
    assign ray_valid_out = vld[2];
    assign ray_last_out = last[2];

    always_ff @(posedge clk_100mhz or posedge rst_in)
        if (rst_in) state <= IDLE;
        else state <= next_state;

    always_comb begin
        next_state = state;
        next_state = (state == IDLE && start_in) ? RUN :
                     (state == RUN && issue && h_end && v_end) ? DRAIN :
                     (state == DRAIN && ray_valid_out && ray_ready_in && ray_last_out) ? IDLE :
                     state;
    end

    always_ff @(posedge clk_100mhz or posedge rst_in)
        if (rst_in) begin
            h_cnt <= '0;
            v_cnt <= '0;
            fwd   <= '0;
            up    <= '0;
            right <= '0;
        end else if (state == IDLE && start_in) begin
            h_cnt <= '0;
            v_cnt <= '0;
            fwd   <= {x_forward_in, y_forward_in, z_forward_in};
            up    <= {x_up_in, y_up_in, z_up_in};
            right <= {x_right_in, y_right_in, z_right_in};
        end else if (issue) begin
            h_cnt <= h_end ? '0 : h_cnt + 1'b1;
            v_cnt <= h_end ? v_cnt + 1'b1 : v_cnt;
        end

    always_ff @(posedge clk_100mhz or posedge rst_in)
        if (rst_in) begin
            vld       <= '0;
            last      <= '0;
            h1        <= '0;
            h2        <= '0;
            pix_h_out <= '0;
            v1        <= '0;
            v2        <= '0;
            pix_v_out <= '0;
        end else if (en) begin
            vld       <= {vld[1:0], issue};
            last      <= {last[1:0], issue && h_end && v_end};
            h1        <= h_cnt;
            h2        <= h1;
            pix_h_out <= h2;
            v1        <= v_cnt;
            v2        <= v1;
            pix_v_out <= v2;
        end

    ray_axis_mac #(.XW(HW + 1), .YW(VW + 1), .SHIFT(PIX_SHIFT)) u_x (
        .clk(clk_100mhz), .rst(rst_in), .en(en), .dx(dx), .dy(dy),
        .fwd(fwd.x), .right(right.x), .up(up.x), .ray(ray_x_out)
    );
    ray_axis_mac #(.XW(HW + 1), .YW(VW + 1), .SHIFT(PIX_SHIFT)) u_y (
        .clk(clk_100mhz), .rst(rst_in), .en(en), .dx(dx), .dy(dy),
        .fwd(fwd.y), .right(right.y), .up(up.y), .ray(ray_y_out)
    );
    ray_axis_mac #(.XW(HW + 1), .YW(VW + 1), .SHIFT(PIX_SHIFT)) u_z (
        .clk(clk_100mhz), .rst(rst_in), .en(en), .dx(dx), .dy(dy),
        .fwd(fwd.z), .right(right.z), .up(up.z), .ray(ray_z_out)
    );
endmodule
